// File: rtl/flag_matcher_pkg.sv
// Shared constants for flag_matcher: state encoding, reference character ROM and LFSR constants.
// FLAG_MATCHER_LFSR_OBF_EN selects a ROM pre-whitened with the LFSR keystream.
package flag_matcher_pkg;

  localparam int DATA_W_DEF   = 7;
  localparam int FLAG_LEN_DEF = 49;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 seen as bits 0,2,3,5 of a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [8*FLAG_LEN_DEF-1:0] FLAG_STR =
    "flag{lfsr_obfuscated_rom_matcher_on_sv_rtl_2024!}";

  typedef logic [FLAG_LEN_DEF-1:0][DATA_W_DEF-1:0] rom_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Character i sits in the low DATA_W bits of byte i (first character is the MSB byte)
  function automatic rom_t build_rom();
    rom_t        r;
    logic [15:0] s;
    r = '{default: {DATA_W_DEF{1'b0}}};
    s = LFSR_SEED;
    for (int i = 0; i < FLAG_LEN_DEF; i++) begin
`ifdef FLAG_MATCHER_LFSR_OBF_EN
      r[i] = FLAG_STR[8*(FLAG_LEN_DEF-1-i) +: DATA_W_DEF] ^ s[DATA_W_DEF-1:0];
      s    = lfsr_next(s);
`else
      r[i] = FLAG_STR[8*(FLAG_LEN_DEF-1-i) +: DATA_W_DEF];
`endif
    end
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

endpackage

// File: rtl/flag_matcher_lfsr.sv
// 16-bit Fibonacci LFSR keystream; exists only when FLAG_MATCHER_LFSR_OBF_EN is defined.
`ifdef FLAG_MATCHER_LFSR_OBF_EN
module flag_lfsr
  import flag_matcher_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reseed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] lfsr_r;

  // Reseed wins over stepping so a cleared submission restarts the keystream at character 0
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else if (reseed) begin
      lfsr_r <= LFSR_SEED;
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign state = lfsr_r;

endmodule
`endif

// File: rtl/flag_matcher.sv
// Sequential flag checker: accepts one character per en and reports win/fail with a running count.
// With FLAG_MATCHER_LFSR_OBF_EN defined, characters are whitened with flag_lfsr before comparison.
module flag_matcher
  import flag_matcher_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FLAG_LEN = FLAG_LEN_DEF,
  parameter int CNT_W    = $clog2(FLAG_LEN + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [DATA_W-1:0] next_byte,
  output logic              win,
  output logic              fail,
  output logic [CNT_W-1:0]  byte_count
);

  state_e             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               win_r, fail_r;
  logic [CNT_W-1:0]   idx_s;
  logic [DATA_W-1:0]  cmp_s;
  logic [DATA_W-1:0]  exp_s;
  logic               match_s;

`ifdef FLAG_MATCHER_LFSR_OBF_EN
  logic [15:0] lfsr_s;

  flag_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reseed (clear),
    .step   (en),
    .state  (lfsr_s)
  );

  assign cmp_s = next_byte ^ lfsr_s[DATA_W-1:0];
`else
  assign cmp_s = next_byte;
`endif

  // ROM index equals characters accepted so far; clamp once past the end
  always_comb begin
    idx_s = {CNT_W{1'b0}};
    if (cnt_r < CNT_W'(FLAG_LEN)) begin
      idx_s = cnt_r;
    end else begin
      idx_s = {CNT_W{1'b0}};
    end
  end

  assign exp_s   = DATA_W'(ROM[idx_s]);
  assign match_s = (cmp_s == exp_s);

  // Next state and count; clear outranks en and discards the same-cycle character
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (clear) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else if (en) begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s   = CNT_W'(1);
          state_nxt_s = match_s ? ST_RUN : ST_FAIL;
        end
        ST_RUN: begin
          if (cnt_r < CNT_W'(FLAG_LEN)) begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            state_nxt_s = match_s ? ST_RUN : ST_FAIL;
          end else begin
            cnt_nxt_s   = CNT_W'(FLAG_LEN + 1);
            state_nxt_s = ST_FAIL;
          end
        end
        ST_FAIL: begin
          state_nxt_s = ST_FAIL;
          if (cnt_r < CNT_W'(FLAG_LEN + 1)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_nxt_s = CNT_W'(FLAG_LEN + 1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // State register; flags are registered from the next-state view so they track the state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      win_r   <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      win_r   <= (state_nxt_s == ST_RUN) && (cnt_nxt_s == CNT_W'(FLAG_LEN));
      fail_r  <= (state_nxt_s == ST_FAIL);
    end
  end

  assign win        = win_r;
  assign fail       = fail_r;
  assign byte_count = cnt_r;

endmodule

// File: tb/tb_flag_matcher.sv
// Scoreboard bench for flag_matcher: driver pushes expectations from a sequence-level model,
// a negedge monitor pops and compares them against win/fail/byte_count.
module tb_flag_matcher;

  localparam int DW   = 7;
  localparam int FLEN = 49;
  localparam int CW   = $clog2(FLEN + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] next_byte = '0;
  logic          win;
  logic          fail;
  logic [CW-1:0] byte_count;

  flag_matcher dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clear      (clear),
    .next_byte  (next_byte),
    .win        (win),
    .fail       (fail),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    bit win;
    bit fail;
    int cnt;
  } exp_t;

  exp_t  q[$];
  int    edge_cnt = 0;
  int    n_checks = 0;
  int    n_pass   = 0;
  string flag_s   = "flag{lfsr_obfuscated_rom_matcher_on_sv_rtl_2024!}";

  // Model state: how many characters were submitted and whether any was wrong or excess
  int acc_n = 0;
  bit bad   = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [DW-1:0] ref_char(input int i);
    byte ch;
    ch = flag_s[i];
    return ch[DW-1:0];
  endfunction

  // Monitor: compare every expectation whose target edge has just occurred
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= edge_cnt) begin
      exp_t x;
      x = q.pop_front();
      n_checks++;
      if (win === x.win && fail === x.fail && byte_count === CW'(x.cnt)) begin
        n_pass++;
      end else begin
        $display("FAIL edge%0d: got win=%b fail=%b count=%0d, expected win=%b fail=%b count=%0d",
                 x.stamp, win, fail, byte_count, x.win, x.fail, x.cnt);
      end
    end
  end

  task automatic step(input bit r, input bit c, input bit e, input logic [DW-1:0] b);
    exp_t x;
    rst = r; clear = c; en = e; next_byte = b;
    if (r || c) begin
      acc_n = 0;
      bad   = 1'b0;
    end else if (e) begin
      if (acc_n >= FLEN || b != ref_char(acc_n)) bad = 1'b1;
      acc_n++;
    end
    x.stamp = edge_cnt + 1;
    x.win   = !bad && (acc_n == FLEN);
    x.fail  = bad;
    x.cnt   = (acc_n > FLEN + 1) ? FLEN + 1 : acc_n;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Submit characters [from, to) of the flag, flipping bit 0 of character bad_idx
  task automatic send_flag(input int from, input int to, input int bad_idx);
    logic [DW-1:0] b;
    for (int i = from; i < to; i++) begin
      b = ref_char(i);
      if (i == bad_idx) b = b ^ 7'h01;
      step(1'b0, 1'b0, 1'b1, b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7'($urandom));
  endtask

  initial begin
    logic [DW-1:0] b;
    int r;

    step(1'b1, 1'b0, 1'b0, 7'h00);
    step(1'b1, 1'b1, 1'b1, 7'h66);
    idle(2);

    // Full correct flag, then hold
    send_flag(0, FLEN, -1);
    idle(3);

    // Correct 36-character prefix, then en low for a while
    step(1'b0, 1'b1, 1'b0, 7'h00);
    send_flag(0, 36, -1);
    idle(10);

    // Character 5 wrong
    step(1'b0, 1'b1, 1'b0, 7'h00);
    send_flag(0, FLEN, 5);
    idle(2);

    // Full flag plus one extra character, then saturation
    step(1'b0, 1'b1, 1'b0, 7'h00);
    send_flag(0, FLEN, -1);
    step(1'b0, 1'b0, 1'b1, ref_char(0));
    step(1'b0, 1'b0, 1'b1, ref_char(1));
    idle(2);

    // Clear after 20 (with a same-cycle en that must be discarded), then full flag
    step(1'b0, 1'b1, 1'b0, 7'h00);
    send_flag(0, 20, -1);
    step(1'b0, 1'b1, 1'b1, ref_char(20));
    send_flag(0, FLEN, -1);
    idle(2);

    // Reset after 30, then full flag
    step(1'b0, 1'b1, 1'b0, 7'h00);
    send_flag(0, 30, -1);
    step(1'b1, 1'b0, 1'b1, ref_char(30));
    send_flag(0, FLEN, -1);
    idle(2);

    // Randomized mix of gaps, occasional errors, clears and resets
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 199);
      if (acc_n < FLEN && $urandom_range(0, 39) != 0) b = ref_char(acc_n);
      else b = 7'($urandom);
      step(r == 0, r > 0 && r < 4, r < 150, b);
    end

    // Bounded drain of outstanding expectations
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
